// File: rtl/ex_result_stage_pkg.sv
// Shared constants and types for the execute-stage result selector and its multiplier.
package ex_pkg;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/ex_result_stage_mult_seq.sv
// Sequential shift-add unsigned 32x32 multiplier, one iteration per cycle while run is high.
// Optional MULT_EARLY_OUT_EN finishes once the remaining multiplier bits are all zero.
module mult_seq
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        run,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0]      mcand;
  logic [63:0]      prod;
  logic [63:0]      prod_nxt;
  logic [31:0]      mplier;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    prod_nxt = mplier[0] ? (prod + mcand) : prod;
    cnt_nxt  = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MULT_EARLY_OUT_EN
    // Shifting out the last set bit means no further additions can occur.
    done = run && ((cnt_nxt == CNT_W'(MUL_ITERS)) || (mplier[31:1] == 31'd0));
`else
    done = run && (cnt_nxt == CNT_W'(MUL_ITERS));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      mcand  <= {32'b0, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (run) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_nxt;
      cnt    <= cnt_nxt;
      if (done) begin
        hi <= prod_nxt[63:32];
        lo <= prod_nxt[31:0];
      end
    end
  end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result mux, HI/LO owner and EX/MEM output register.
// Build option MULT_EARLY_OUT_EN shortens MULTU latency to the multiplier's significant bits.
//
// state | meaning
// IDLE  | accepting instructions, output register follows selected result
// MUL   | MULTU iterating, upstream stalled, output register loads bubbles
module ex_result_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [31:0] aluOut,
  input  logic [31:0] shiftOut,
  input  logic [4:0]  rd_in,
  input  logic        regWrite_in,
  output logic [31:0] dataOut,
  output logic [4:0]  rd_out,
  output logic        regWrite_out,
  output logic        valid_out,
  output logic        stall
);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] data_nxt;
  logic [4:0]  rd_nxt;
  logic        regwrite_nxt;
  logic        valid_nxt;

  mult_seq u_mult (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .run   (state == MUL),
    .a     (dataA),
    .b     (dataB),
    .done  (mul_done),
    .hi    (hi),
    .lo    (lo)
  );

  assign accept    = valid_in && (state == IDLE);
  assign mul_start = accept && (Signal == FUNCT_MULTU);
  assign stall     = (state == MUL);

  always_comb begin
    state_nxt    = state;
    data_nxt     = '0;
    rd_nxt       = '0;
    regwrite_nxt = 1'b0;
    valid_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          rd_nxt       = rd_in;
          regwrite_nxt = regWrite_in;
          valid_nxt    = 1'b1;
          case (Signal)
            FUNCT_SLL:   data_nxt = shiftOut;
            FUNCT_MFHI:  data_nxt = hi;
            FUNCT_MFLO:  data_nxt = lo;
            FUNCT_MULTU: begin
              regwrite_nxt = 1'b0;
              state_nxt    = MUL;
            end
            default:     data_nxt = aluOut;
          endcase
        end
      end
      MUL: begin
        if (mul_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dataOut      <= '0;
      rd_out       <= '0;
      regWrite_out <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      state        <= state_nxt;
      dataOut      <= data_nxt;
      rd_out       <= rd_nxt;
      regWrite_out <= regwrite_nxt;
      valid_out    <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: pass-through, HI/LO, MULTU latency, reset and issue under stall.
module tb_ex_result_stage;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_ADD   = 6'b100000;

`ifdef MULT_EARLY_OUT_EN
  localparam int EXP_3X5 = 3;
  localparam int EXP_7X9 = 4;
`else
  localparam int EXP_3X5 = 32;
  localparam int EXP_7X9 = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] aluOut;
  logic [31:0] shiftOut;
  logic [4:0]  rd_in;
  logic        regWrite_in;
  logic [31:0] dataOut;
  logic [4:0]  rd_out;
  logic        regWrite_out;
  logic        valid_out;
  logic        stall;

  int errors = 0;
  int checks = 0;
  int n;

  ex_result_stage dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .Signal       (Signal),
    .dataA        (dataA),
    .dataB        (dataB),
    .aluOut       (aluOut),
    .shiftOut     (shiftOut),
    .rd_in        (rd_in),
    .regWrite_in  (regWrite_in),
    .dataOut      (dataOut),
    .rd_out       (rd_out),
    .regWrite_out (regWrite_out),
    .valid_out    (valid_out),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [4:0] rd, input logic rw);
    valid_in    = 1'b1;
    Signal      = f;
    rd_in       = rd;
    regWrite_in = rw;
    tick();
    valid_in    = 1'b0;
  endtask

  // Counts stall cycles after a MULTU accept, checking every output is a bubble meanwhile.
  task automatic count_stall(input string tag, output int cnt);
    cnt = 0;
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
      check({tag, "_bubble_valid"}, 32'(valid_out), 32'd0);
      check({tag, "_bubble_rw"}, 32'(regWrite_out), 32'd0);
      check({tag, "_bubble_data"}, dataOut, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    valid_in = 1'($urandom); Signal = 6'($urandom); dataA = $urandom; dataB = $urandom;
    aluOut = $urandom; shiftOut = $urandom; rd_in = 5'($urandom); regWrite_in = 1'($urandom);
    tick();
    valid_in = 1'($urandom); Signal = 6'($urandom); rd_in = 5'($urandom);
    tick();
    reset = 1'b0;
    valid_in = 1'b0;
    check("rst_data", dataOut, 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_rw", 32'(regWrite_out), 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    issue(F_MFHI, 5'd2, 1'b1);
    check("rst_mfhi", dataOut, 32'd0);

    shiftOut = 32'h0000_0010; aluOut = 32'hDEAD_BEEF;
    issue(F_SLL, 5'd5, 1'b1);
    check("sll_data", dataOut, 32'h0000_0010);
    check("sll_rd", 32'(rd_out), 32'd5);
    check("sll_rw", 32'(regWrite_out), 32'd1);
    check("sll_valid", 32'(valid_out), 32'd1);

    aluOut = 32'h1234_5678;
    issue(F_ADD, 5'd9, 1'b0);
    check("alu_data", dataOut, 32'h1234_5678);
    check("alu_rw", 32'(regWrite_out), 32'd0);

    tick();
    check("idle_bubble_valid", 32'(valid_out), 32'd0);
    check("idle_bubble_data", dataOut, 32'd0);

    dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
    issue(F_MULTU, 5'd7, 1'b1);
    check("mul_acc_valid", 32'(valid_out), 32'd1);
    check("mul_acc_rw", 32'(regWrite_out), 32'd0);
    check("mul_acc_data", dataOut, 32'd0);
    check("mul_acc_stall", 32'(stall), 32'd1);
    count_stall("full", n);
    check("full_stall_len", 32'(n), 32'd32);
    issue(F_MFHI, 5'd1, 1'b1);
    check("full_hi", dataOut, 32'hFFFF_FFFE);
    issue(F_MFLO, 5'd2, 1'b1);
    check("full_lo", dataOut, 32'h0000_0001);

    shiftOut = 32'hA5A5_0000;
    issue(F_SLL, 5'd3, 1'b1);
    issue(F_MFHI, 5'd1, 1'b1);
    check("hi_kept", dataOut, 32'hFFFF_FFFE);

    dataA = 32'd3; dataB = 32'd5;
    issue(F_MULTU, 5'd0, 1'b0);
    count_stall("small", n);
    check("small_stall_len", 32'(n), 32'(EXP_3X5));
    issue(F_MFLO, 5'd4, 1'b1);
    check("small_lo", dataOut, 32'd15);
    issue(F_MFHI, 5'd4, 1'b1);
    check("small_hi", dataOut, 32'd0);

    dataA = 32'd7; dataB = 32'd9;
    issue(F_MULTU, 5'd0, 1'b0);
    valid_in = 1'b1; Signal = F_MFLO; rd_in = 5'd3; regWrite_in = 1'b1;
    count_stall("held", n);
    check("held_stall_len", 32'(n), 32'(EXP_7X9));
    check("held_not_yet", 32'(valid_out), 32'd0);
    tick();
    valid_in = 1'b0;
    check("held_lo", dataOut, 32'd63);
    check("held_valid", 32'(valid_out), 32'd1);
    check("held_rd", 32'(rd_out), 32'd3);

    dataA = 32'hFFFF_FFFF; dataB = 32'hFFFF_FFFF;
    issue(F_MULTU, 5'd0, 1'b0);
    n = 0;
    while (stall === 1'b1 && n < 10) begin
      n++;
      if (n < 10) tick();
    end
    check("pre_rst_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_data", dataOut, 32'd0);
    issue(F_MFHI, 5'd1, 1'b1);
    check("mid_rst_hi", dataOut, 32'd0);
    issue(F_MFLO, 5'd1, 1'b1);
    check("mid_rst_lo", dataOut, 32'd0);
    aluOut = 32'd7;
    issue(F_ADD, 5'd8, 1'b1);
    check("post_rst_add", dataOut, 32'd7);
    check("post_rst_rd", 32'(rd_out), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
